// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared mode encodings, fill kinds and mode helpers for the pipelined barrel shifter.
package barrel_pkg;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  // What a mux level shifts in at the top when it is enabled
  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_SIGN = 2'd1,
    FILL_ROT  = 2'd2
  } fill_e;

  // Left operations run on the bit-reversed operand
  function automatic logic is_left(input logic [2:0] mode);
    return (mode == MODE_SLL) || (mode == MODE_ROL);
  endfunction

  function automatic logic is_legal(input logic [2:0] mode);
    return mode <= MODE_ROR;
  endfunction

  function automatic fill_e fill_of(input logic [2:0] mode);
    fill_e f;
    case (mode)
      MODE_SRA:          f = FILL_SIGN;
      MODE_ROL, MODE_ROR: f = FILL_ROT;
      default:           f = FILL_ZERO;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/barrel_shifter_pipe_level.sv
// One combinational mux level: optionally shifts right by STEP, filling the top STEP bits.
module barrel_shift_level
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  fill_e            fill_mode,
  input  logic             sign,
  output logic [WIDTH-1:0] data_o
);

  logic [STEP-1:0] w_fill;

  // Choose the bits entering at the top and apply the shift when enabled
  always_comb begin
    w_fill = '0;
    case (fill_mode)
      FILL_SIGN: w_fill = {STEP{sign}};
      FILL_ROT:  w_fill = data[STEP-1:0];
      default:   w_fill = '0;
    endcase
    data_o = en ? {w_fill, data[WIDTH-1:STEP]} : data;
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides and a global stall.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [$clog2(WIDTH)-1:0]  in_amt,
  input  logic [2:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_err
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int NSTG = (SHW + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  function automatic logic [WIDTH-1:0] bitRev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  logic [NSTG-1:0]  r_valid;
  logic [WIDTH-1:0] r_data [NSTG];
  logic [SHW-1:0]   r_amt  [NSTG];
  logic [2:0]       r_mode [NSTG];
  logic             r_sign [NSTG];

  logic [WIDTH-1:0] w_stgData [NSTG];
  logic [SHW-1:0]   w_stgAmt  [NSTG];
  logic [2:0]       w_stgMode [NSTG];
  logic             w_stgSign [NSTG];
  logic [WIDTH-1:0] w_stgOut  [NSTG];

  logic [WIDTH-1:0] w_lvlIn   [SHW];
  logic [WIDTH-1:0] w_lvlOut  [SHW];
  logic             w_lvlEn   [SHW];
  fill_e            w_lvlFill [SHW];

  logic w_advance;

  assign w_advance = !r_valid[NSTG-1] || out_ready;
  assign in_ready  = w_advance;

  // Stage inputs: stage 0 takes the operand (reversed for left ops), later stages the previous register
  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    localparam int LASTLVL =
      (((s + 1) * LEVELS_PER_STAGE < SHW) ? (s + 1) * LEVELS_PER_STAGE : SHW) - 1;
    if (s == 0) begin : g_first
      assign w_stgData[s] = is_left(in_mode) ? bitRev(in_data) : in_data;
      assign w_stgAmt[s]  = in_amt;
      assign w_stgMode[s] = in_mode;
      assign w_stgSign[s] = in_data[WIDTH-1];
    end else begin : g_later
      assign w_stgData[s] = r_data[s-1];
      assign w_stgAmt[s]  = r_amt[s-1];
      assign w_stgMode[s] = r_mode[s-1];
      assign w_stgSign[s] = r_sign[s-1];
    end
    assign w_stgOut[s] = w_lvlOut[LASTLVL];
  end

  // Mux levels: level k shifts by 2^k; the first level of each stage starts from that stage's input
  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    localparam int S = k / LEVELS_PER_STAGE;
    if (k % LEVELS_PER_STAGE == 0) begin : g_head
      assign w_lvlIn[k] = w_stgData[S];
    end else begin : g_chain
      assign w_lvlIn[k] = w_lvlOut[k-1];
    end
    assign w_lvlEn[k]   = w_stgAmt[S][k] && is_legal(w_stgMode[S]);
    assign w_lvlFill[k] = fill_of(w_stgMode[S]);

    barrel_shift_level #(
      .WIDTH (WIDTH),
      .STEP  (1 << k)
    ) u_level (
      .data      (w_lvlIn[k]),
      .en        (w_lvlEn[k]),
      .fill_mode (w_lvlFill[k]),
      .sign      (w_stgSign[S]),
      .data_o    (w_lvlOut[k])
    );
  end

  // Pipeline registers: all stages advance together or all hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < NSTG; s++) begin
        r_data[s] <= '0;
        r_amt[s]  <= '0;
        r_mode[s] <= MODE_SLL;
        r_sign[s] <= 1'b0;
      end
    end else if (w_advance) begin
      r_valid[0] <= in_valid;
      for (int s = 1; s < NSTG; s++) r_valid[s] <= r_valid[s-1];
      for (int s = 0; s < NSTG; s++) begin
        r_data[s] <= w_stgOut[s];
        r_amt[s]  <= w_stgAmt[s];
        r_mode[s] <= w_stgMode[s];
        r_sign[s] <= w_stgSign[s];
      end
    end
  end

  assign out_valid = r_valid[NSTG-1];
  assign out_data  = is_left(r_mode[NSTG-1]) ? bitRev(r_data[NSTG-1]) : r_data[NSTG-1];
  assign out_err   = r_valid[NSTG-1] && !is_legal(r_mode[NSTG-1]);

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe: 32-bit/2-level and 8-bit/3-level instances against an arithmetic model.
module tb_barrel_shifter_pipe;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inData = '0;
  logic [4:0]  inAmt = '0;
  logic [2:0]  inMode = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] outData;
  logic        outErr;

  logic       d8InValid = 1'b0;
  logic       d8InReady;
  logic [7:0] d8InData = '0;
  logic [2:0] d8InAmt = '0;
  logic [2:0] d8InMode = '0;
  logic       d8OutValid;
  logic [7:0] d8OutData;
  logic       d8OutErr;

  int   checkCount = 0;
  int   errorCount = 0;
  int   cycle = 0;
  int   resultCount = 0;
  int   firstCycle = 0;
  int   lastCycle = 0;
  exp_t expQ[$];

  barrel_shifter_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(2)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .in_amt    (inAmt),
    .in_mode   (inMode),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_err   (outErr)
  );

  barrel_shifter_pipe #(.WIDTH(8), .LEVELS_PER_STAGE(3)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d8InValid),
    .in_ready  (d8InReady),
    .in_data   (d8InData),
    .in_amt    (d8InAmt),
    .in_mode   (d8InMode),
    .out_valid (d8OutValid),
    .out_ready (1'b1),
    .out_data  (d8OutData),
    .out_err   (d8OutErr)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference: the operations as plain 32-bit arithmetic
  function automatic exp_t refModel(input logic [31:0] d, input int amt, input logic [2:0] mode);
    exp_t e;
    e.err = 1'b0;
    case (mode)
      3'd0: e.data = d << amt;
      3'd1: e.data = d >> amt;
      3'd2: e.data = $signed(d) >>> amt;
      3'd3: e.data = (d << amt) | (d >> (32 - amt));
      3'd4: e.data = (d >> amt) | (d << (32 - amt));
      default: begin
        e.data = d;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Scoreboard on the falling edge: drain handshakes are checked, accepts are predicted
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
    end else begin
      if (outValid && outReady) begin
        resultCount++;
        if (resultCount == 1) firstCycle = cycle;
        lastCycle = cycle;
        checkOutput("result was expected", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("stream data", outData, e.data);
          checkOutput("stream err", outErr, e.err);
        end
      end
      if (inValid && inReady) expQ.push_back(refModel(inData, int'(inAmt), inMode));
    end
  end

  task automatic applyStimulus(input string tag, input logic [31:0] d, input logic [4:0] a,
                               input logic [2:0] m, input logic [31:0] expD, input logic expE);
    int edges;
    inData = d; inAmt = a; inMode = m; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    edges = 1;
    while (!outValid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({tag, " latency"}, 64'(edges), 64'd3);
    checkOutput({tag, " data"}, outData, expD);
    checkOutput({tag, " err"}, outErr, expE);
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus8(input string tag, input logic [7:0] d, input logic [2:0] a,
                                input logic [2:0] m, input logic [7:0] expD);
    int edges;
    d8InData = d; d8InAmt = a; d8InMode = m; d8InValid = 1'b1;
    @(posedge clk); #1;
    d8InValid = 1'b0;
    edges = 1;
    while (!d8OutValid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({tag, " latency"}, 64'(edges), 64'd1);
    checkOutput({tag, " data"}, d8OutData, expD);
    checkOutput({tag, " err"}, d8OutErr, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic randomOp();
    inData = $urandom;
    inAmt  = 5'($urandom_range(0, 31));
    inMode = 3'($urandom_range(0, 4));
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL global timeout reached");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus sequence
  initial begin
    #2;
    checkOutput("reset out_valid", outValid, 1'b0);
    checkOutput("reset out_data", outData, 32'h0);
    checkOutput("reset out_err", outErr, 1'b0);
    checkOutput("reset in_ready", inReady, 1'b1);
    checkOutput("reset 8b out_valid", d8OutValid, 1'b0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus8("w8 SLL", 8'b00001111, 3'd3, 3'b000, 8'b01111000);
    applyStimulus8("w8 SRL", 8'b01010101, 3'd2, 3'b001, 8'b00010101);

    applyStimulus("SRA neg", 32'h8000_0000, 5'd4, 3'b010, 32'hF800_0000, 1'b0);
    applyStimulus("SRA pos", 32'h7000_0000, 5'd4, 3'b010, 32'h0700_0000, 1'b0);
    applyStimulus("ROL",     32'h8000_0001, 5'd1, 3'b011, 32'h0000_0003, 1'b0);
    applyStimulus("ROR",     32'h0000_0001, 5'd31, 3'b100, 32'h0000_0002, 1'b0);
    applyStimulus("SLL amt0", 32'hDEAD_BEEF, 5'd0, 3'b000, 32'hDEAD_BEEF, 1'b0);
    applyStimulus("illegal", 32'h1234_5678, 5'd7, 3'b110, 32'h1234_5678, 1'b1);
    applyStimulus("after illegal", 32'h1234_5678, 5'd4, 3'b001, 32'h0123_4567, 1'b0);

    // Back-to-back random stream
    resultCount = 0;
    for (int i = 0; i < 16; i++) begin
      randomOp();
      inValid = 1'b1;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    checkOutput("b2b count", 64'(resultCount), 64'd16);
    checkOutput("b2b consecutive", 64'(lastCycle - firstCycle), 64'd15);
    checkOutput("b2b queue empty", 64'(expQ.size()), 64'd0);

    // Backpressure with a full pipe and one more op waiting
    resultCount = 0;
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomOp();
      inValid = 1'b1;
      @(posedge clk); #1;
    end
    randomOp();
    for (int j = 0; j < 5; j++) begin
      checkOutput("stall in_ready", inReady, 1'b0);
      checkOutput("stall out_valid", outValid, 1'b1);
      checkOutput("stall out_data", outData, expQ.size() != 0 ? expQ[0].data : 32'hx);
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    checkOutput("drain count", 64'(resultCount), 64'd4);
    checkOutput("drain queue empty", 64'(expQ.size()), 64'd0);

    // Reset with two operations in flight
    for (int i = 0; i < 2; i++) begin
      randomOp();
      inValid = 1'b1;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset out_valid", outValid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("post reset in_ready", inReady, 1'b1);
    resultCount = 0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    checkOutput("flushed ops emerged", 64'(resultCount), 64'd0);

    applyStimulus("post reset ROR", 32'hF000_000F, 5'd8, 3'b100, 32'h0FF0_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter: successor to the 8-bit combinational shifter. It supports logical left, logical right, arithmetic right, rotate-left and rotate-right on a WIDTH-bit operand. A valid/ready handshake on both sides lets it sit directly in a datapath between a streaming producer and consumer. Latency is fixed and set at elaboration; throughput is one operation per cycle when not back-pressured.

## Interface
- WIDTH, 32, operand width; power of two, ≥ 2.
- LEVELS_PER_STAGE, 2, mux levels (log2 shift steps) between pipeline registers; ≥ 1.
- Derived (localparam, not overridable): SHW = $clog2(WIDTH); NSTG = ceil(SHW / LEVELS_PER_STAGE).

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst_n, input, 1, asynchronous, active-low reset.
- in_valid, input, 1, an operation is presented.
- in_ready, output, 1, the operation is accepted this cycle when in_valid && in_ready.
- in_data, input, WIDTH, operand.
- in_amt, input, SHW, shift/rotate amount, 0..WIDTH-1.
- in_mode, input, 3, operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 illegal.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer takes the result when out_valid && out_ready.
- out_data, output, WIDTH, result.
- out_err, output, 1, result came from an illegal mode; qualified by out_valid.

## Operation
- Left operations (SLL, ROL) are computed as right operations on the bit-reversed operand; the result is bit-reversed back.
- Level k (k = 0..SHW-1) shifts right by 2^k when amt[k] = 1.
- Fill bits per level:
  - SLL/SRL: 0.
  - SRA: operand MSB, captured at input.
  - ROL/ROR: bits wrapped from the low end.
- amt = 0 gives out_data = in_data for every legal mode.
- Illegal mode: out_data = in_data unshifted, out_err = 1. Otherwise out_err = 0.
- Mode, amount and sign travel down the pipeline with the data. Each stage carries a valid bit.
- Global stall rule: advance = !out_valid || out_ready.
  - in_ready = advance (combinational from out_valid/out_ready only; never from in_valid).
  - When advance = 0, every stage holds and out_data/out_valid/out_err stay stable.
  - When advance = 1, every stage shifts forward one step. Stage 0 loads in_valid && in_ready; bubbles propagate as valid = 0.
- No bubble collapsing; a stalled pipeline holds internal bubbles.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits = 0, out_valid = 0, out_data = 0, out_err = 0. in_ready = 1 one combinational evaluation after reset deassertion.
- Reset mid-operation discards all in-flight operations; nothing emerges afterwards.
- Latency: an operation accepted at edge t has out_valid = 1 after edge t+NSTG-1 (NSTG register stages, with the last stage driving the outputs), given no stall.
  - Example: WIDTH = 32, LEVELS_PER_STAGE = 2 gives NSTG = 3.
  - Example: WIDTH = 8, LEVELS_PER_STAGE = 3 gives NSTG = 1.
- Throughput: 1 op/cycle while out_ready = 1.
- Simultaneous accept and drain: allowed in the same cycle (out_valid && out_ready && in_valid).
- Once out_valid is asserted it stays high, with out_data constant, until the handshake completes.

## Structure
- Package barrel_pkg holds:
  - mode encodings as localparams: MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR.
  - a function is_left(mode).
  - a function is_legal(mode).
- Sub-module barrel_shift_level, one combinational mux level:
  - parameters WIDTH and STEP.
  - inputs data, en, fill_mode, sign.
  - output data_o.
  - instantiated SHW times by a generate loop.
- Pipeline registers are inserted after every LEVELS_PER_STAGE levels and after the final level.

## Test plan
- WIDTH = 8, LEVELS_PER_STAGE = 3: SLL 8'b00001111, amt 3 → 8'b01111000 one cycle later. SRL 8'b01010101, amt 2 → 8'b00010101.
- WIDTH = 32: SRA 0x8000_0000, amt 4 → 0xF800_0000. SRA 0x7000_0000, amt 4 → 0x0700_0000. ROL 0x8000_0001, amt 1 → 0x0000_0003. ROR 0x0000_0001, amt 31 → 0x0000_0002. Latency is exactly 3 for each.
- Back-to-back: 16 random ops with out_ready = 1 → 16 results in order on consecutive cycles, all matching the reference model.
- Backpressure: hold out_ready = 0 for 5 cycles with the pipe full → in_ready = 0 and out_data stable. Release → results drain in order with no loss or duplication.
- Illegal mode 3'b110 with 0x1234_5678, amt 7 → out_data = 0x1234_5678, out_err = 1. A following legal op → out_err = 0.
- Assert rst_n = 0 for 1 cycle with 2 ops in flight → out_valid = 0 immediately, neither op ever emerges, and in_ready = 1 after release.
